// File: rtl/x400_pkg.sv
// Shared constants and fill-state encoding for the 400-bit operand collector.
package x400_pkg;
  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 25;
  localparam int OPERAND_W = 400;
  localparam int MOD_P     = 4051;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } fill_state_e;
endpackage

// File: rtl/x400_word_cnt.sv
// Word index counter: counts accepted words, flags the final word of an
// operand, wraps to zero after it and supports a synchronous clear.
module x400_word_cnt
  import x400_pkg::*;
#(
  parameter int NUM_WORDS = x400_pkg::NUM_WORDS,
  parameter int CNT_W     = x400_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign term = (cnt_q == CNT_W'(NUM_WORDS - 1));
  assign cnt  = cnt_q;

  // Next count: clear wins, otherwise step and wrap after the last word.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = term ? '0 : cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/x400_collect.sv
// Collects NUM_WORDS input words (LS word first) into one 400-bit operand
// for the downstream mod-4051 reduction stage. Two-deep: a staging register
// fills while the output register holds the previous operand.
// Optional framing check (in_last vs. word count, sticky err output) is
// built only when X400_COLLECT_ERR_EN is defined.
module x400_collect
  import x400_pkg::*;
#(
  parameter int WORD_W    = x400_pkg::WORD_W,
  parameter int NUM_WORDS = x400_pkg::NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [WORD_W*NUM_WORDS-1:0] x_out,
  output logic                        x_valid,
  input  logic                        x_ready
`ifdef X400_COLLECT_ERR_EN
  ,
  output logic                        err
`endif
);

  localparam int OP_W  = WORD_W * NUM_WORDS;
  localparam int CNT_W = $clog2(NUM_WORDS);

  fill_state_e      state_q, state_d;
  logic [OP_W-1:0]  stg_q, stg_d;
  logic [OP_W-1:0]  xout_q, xout_d;
  logic             xv_q, xv_d;
  logic [CNT_W-1:0] cnt;
  logic             term;
  logic             acc;
  logic             move;
  logic             drop;

  assign acc  = in_valid & in_ready;
  // Staging leaves when the output register is empty or emptying this cycle.
  assign move = (state_q == FULL) & (~xv_q | x_ready);

`ifdef X400_COLLECT_ERR_EN
  logic err_q, err_d;

  // Early in_last abandons the partial operand.
  assign drop = acc & in_last & ~term;

  // Sticky framing error: early in_last, or final word without in_last.
  always_comb begin
    err_d = err_q | drop | (acc & term & ~in_last);
  end

  // Error flag register; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  // Without framing checks the word count alone delimits operands.
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign drop           = 1'b0;
`endif

  x400_word_cnt #(
    .NUM_WORDS (NUM_WORDS),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (acc),
    .clr  (drop),
    .cnt  (cnt),
    .term (term)
  );

  // Fill state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Fill state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FILL: begin
        if (acc) begin
          if (drop)      state_d = IDLE;
          else if (term) state_d = FULL;
          else           state_d = FILL;
        end
      end
      FULL:    if (move) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accept words whenever staging has room; held low throughout reset.
  always_comb begin
    in_ready = ~rst & (state_q != FULL);
  end

  // Staging write and output register load/consume.
  always_comb begin
    stg_d  = stg_q;
    xout_d = xout_q;
    xv_d   = xv_q;
    if (acc) stg_d[int'(cnt)*WORD_W +: WORD_W] = in_data;
    if (move) begin
      xout_d = stg_q;
      xv_d   = 1'b1;
    end else if (xv_q & x_ready) begin
      xv_d   = 1'b0;
    end
  end

  // Data registers carry no reset; x_valid qualifies x_out.
  always_ff @(posedge clk) begin
    stg_q  <= stg_d;
    xout_q <= xout_d;
  end

  // Output valid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) xv_q <= 1'b0;
    else     xv_q <= xv_d;
  end

  assign x_out   = xout_q;
  assign x_valid = xv_q;

endmodule

// File: tb/tb_x400_collect.sv
// Self-checking bench for x400_collect. A word-level model assembles
// operands into an expected queue; every negedge the DUT output is compared
// against it. Directed literal checks pin latency, ordering and framing.
// Build with +define+X400_COLLECT_ERR_EN to exercise the framing checks.
module tb_x400_collect;
  import x400_pkg::*;

  localparam int W  = WORD_W;
  localparam int NW = NUM_WORDS;
  localparam int OW = OPERAND_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [OW-1:0] x_out;
  logic          x_valid;
  logic          x_ready = 1'b0;
`ifdef X400_COLLECT_ERR_EN
  logic          err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int hs     = 0;
  int ir_low = 0;
  int idx    = 0;
  logic [OW-1:0] asm_buf = '0;
  logic [OW-1:0] exp_q[$];
  logic          err_m = 1'b0;

  always #5 clk = ~clk;

  x400_collect dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .x_out    (x_out),
    .x_valid  (x_valid),
    .x_ready  (x_ready)
`ifdef X400_COLLECT_ERR_EN
    ,
    .err      (err)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Residue of a 400-bit value by bitwise Horner evaluation.
  function automatic int residue(input logic [OW-1:0] x);
    int r = 0;
    for (int i = OW - 1; i >= 0; i--) r = (r * 2 + int'(x[i])) % MOD_P;
    return r;
  endfunction

  // (2^400 - 1) mod p via repeated doubling.
  function automatic int ref_all_ones();
    int r = 1;
    for (int i = 0; i < OW; i++) r = (r * 2) % MOD_P;
    return (r + MOD_P - 1) % MOD_P;
  endfunction

  // Per-cycle compare against the model, then advance the model by this
  // cycle's handshakes (inputs seen here are those sampled at the next edge).
  task automatic model_cycle();
    if (rst) begin
      exp_q.delete();
      idx   = 0;
      err_m = 1'b0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_x_valid", x_valid, 0);
      return;
    end
    if (x_valid === 1'b1) begin
      chk("xv_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chkw("x_out", x_out, exp_q[0]);
        if (x_ready) begin
          void'(exp_q.pop_front());
          hs++;
        end
      end
    end
    if (in_ready !== 1'b1) ir_low++;
`ifdef X400_COLLECT_ERR_EN
    chk("err", err, err_m);
`endif
    if (in_valid && in_ready === 1'b1) begin
`ifdef X400_COLLECT_ERR_EN
      if (in_last && idx != NW - 1) begin
        err_m = 1'b1;
        idx   = 0;
        return;
      end
      if (!in_last && idx == NW - 1) err_m = 1'b1;
`endif
      asm_buf[idx*W +: W] = in_data;
      idx++;
      if (idx == NW) begin
        exp_q.push_back(asm_buf);
        idx = 0;
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin neg(); pos(); end
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    bit ok = 1'b0;
    int t  = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      model_cycle();
      pos();
      t++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_op(input logic [W-1:0] base);
    for (int k = 0; k < NW; k++) send(base + W'(k), (k == NW - 1));
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (hs < target && t < 60) begin neg(); pos(); t++; end
    chk("hs_count", hs, target);
  endtask

  initial begin
    int h0;
    #1 rst = 1'b1;
    pos();
    steps(3);
    rst = 1'b0;
    neg();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_x_valid", x_valid, 0);
    pos();

    // Basic operand 0x0001..0x0019 and latency of one cycle after last word.
    x_ready = 1'b1;
    for (int k = 1; k <= NW; k++) send(W'(k), (k == NW));
    neg();
    chk("lat_not_yet", x_valid, 0);
    pos();
    neg();
    chk("lat_valid", x_valid, 1);
    chk("first_word", x_out[15:0], 16'h0001);
    chk("last_word", x_out[399:384], 16'h0019);
    pos();
    wait_hs(1);

    // Back-pressure: two operands with x_ready low, then drain in order.
    x_ready = 1'b0;
    h0 = hs;
    send_op(16'h0100);
    send_op(16'h0200);
    steps(2);
    neg();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_x_valid", x_valid, 1);
    chk("bp_held_word", x_out[15:0], 16'h0100);
    pos();
    x_ready = 1'b1;
    wait_hs(h0 + 2);

    // Streaming four operands: one in_ready bubble per operand.
    steps(2);
    h0     = hs;
    ir_low = 0;
    for (int o = 1; o <= 4; o++) send_op(W'(o * 16'h1000));
    steps(5);
    chk("stream_hs", hs - h0, 4);
    chk("stream_bubbles", ir_low, 4);

    // Reset mid-operand discards the partial operand.
    h0 = hs;
    for (int k = 0; k < 10; k++) send(16'hA000 + W'(k), 1'b0);
    rst = 1'b1;
    neg();
    pos();
    rst = 1'b0;
    steps(30);
    chk("rst_no_delivery", hs, h0);
    send_op(16'hB000);
    wait_hs(h0 + 1);

    // All-ones operand and its downstream residue.
    for (int k = 0; k < NW; k++) send(16'hFFFF, (k == NW - 1));
    neg();
    chk("ones_not_yet", x_valid, 0);
    pos();
    neg();
    chkw("ones_value", x_out, {OW{1'b1}});
    chk("ones_residue", residue(x_out), ref_all_ones());
    pos();
    steps(2);

`ifdef X400_COLLECT_ERR_EN
    // Early in_last on word 7: error, partial dropped, next operand intact.
    h0 = hs;
    for (int k = 0; k < 7; k++) send(16'hE000 + W'(k), (k == 6));
    neg();
    chk("err_set", err, 1);
    pos();
    send_op(16'hC000);
    wait_hs(h0 + 1);
    neg();
    chk("err_sticky", err, 1);
    pos();
`endif

    steps(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/x400_collect.md
X400_COLLECT -- requirements
Module: x400_collect

Interface
REQ-001 Parameter WORD_W, default 16: input word width in bits.
REQ-002 Parameter NUM_WORDS, default 25: words per operand, so NUM_WORDS*WORD_W = 400.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WORD_W  operand word; the first word is the least-significant slice X[16:1].
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_last  input  1  marks the final word of an operand; qualified by in_valid.
REQ-008 in_ready  output  1  collector accepts a word this cycle.
REQ-009 x_out  output  400  assembled operand X[400:1], presented to the downstream 400-bit mod-4051 reduction stage.
REQ-010 x_valid  output  1  x_out holds a complete operand.
REQ-011 x_ready  input  1  downstream consumes x_out this cycle.
REQ-012 err  output  1  sticky framing-error flag; present only when X400_COLLECT_ERR_EN is defined.

Function
REQ-013 A word transfers when in_valid and in_ready are both high; an operand transfers when x_valid and x_ready are both high.
REQ-014 The collector has a fill register (staging) and an output register (x_out), giving two-deep buffering.
REQ-015 Fill state machine: IDLE (cnt=0), FILL (0<cnt<NUM_WORDS), FULL (staging complete, waiting for the output register).
REQ-016 Word k (k=0..24) is written to staging bits [16k+16 : 16k+1]; the 5-bit cnt increments on each accepted word.
REQ-017 The transition to FULL occurs on acceptance of word 24; cnt returns to 0.
REQ-018 In FULL, staging moves to x_out on the first cycle in which the output register is empty or being consumed the same cycle; the state then returns to IDLE.
REQ-019 in_ready = 1 in IDLE and FILL; in_ready = 0 in FULL.
REQ-020 x_valid rises one cycle after the staging-to-output move and stays high, with x_out stable, until an operand handshake completes.
REQ-021 Latency: the last word is accepted at edge N; with the output register free, x_valid = 1 after edge N+1.
REQ-022 Simultaneous consume and move: x_valid stays 1 and x_out takes the new operand with no bubble.
REQ-023 Throughput: with x_ready held at 1, one operand completes every 25 accepted words, and in_ready drops for exactly one cycle per operand.
REQ-024 in_last has no framing effect unless X400_COLLECT_ERR_EN is defined; the word count alone delimits operands.

Reset
REQ-025 During rst: state = IDLE, cnt = 0, x_valid = 0, err = 0, in_ready = 0.
REQ-026 In the first cycle after rst deasserts: in_ready = 1.
REQ-027 x_out and the staging register need not be reset; x_out is don't-care while x_valid = 0.
REQ-028 rst asserted mid-operand discards the partial operand and any held output operand.

Configuration
REQ-029 Macro X400_COLLECT_ERR_EN controls framing checks.
REQ-030 Defined: err is set on (a) in_last = 1 with a word index other than 24, or (b) word 24 accepted with in_last = 0.
REQ-031 Defined, case (a): the partial operand is dropped and cnt resets to 0.
REQ-032 Defined, case (b): the operand is still delivered.
REQ-033 Defined: err clears only on rst.
REQ-034 Undefined: the err port and all checking logic are absent.

Structure
REQ-035 A shared package x400_pkg holds WORD_W, NUM_WORDS, OPERAND_W=400, MOD_P=4051, and the fill-state enum {IDLE, FILL, FULL}.
REQ-036 One sub-module, x400_word_cnt, implements the 5-bit word counter with terminal flag at 24 and synchronous clear.
REQ-037 x400_collect contains no reduction arithmetic; the residue is computed by the downstream stage.

Verification
REQ-038 Reset, then 25 words 0x0001..0x0019 with in_last on word 25, x_ready = 1 -> x_valid one cycle after the last word; x_out[16:1] = 0x0001 and x_out[400:385] = 0x0019.
REQ-039 x_ready = 0 while two operands stream in -> first operand held stable; in_ready = 0 after the second fills; with x_ready = 1, both operands delivered in order with no loss.
REQ-040 Continuous in_valid and x_ready for 4 operands -> exactly 4 x_valid handshakes and in_ready low for 1 cycle per operand.
REQ-041 rst pulsed after word 10 -> no x_valid; the next 25-word operand is delivered correctly.
REQ-042 X400_COLLECT_ERR_EN defined: in_last on word 7 -> err = 1 and the partial operand dropped; a following clean operand is delivered with err still 1.
REQ-043 All-0xFFFF operand -> x_out equals 400 ones; the downstream residue checked against 2^400-1 mod 4051 from a reference model.
